sa_skew_feeder: RTL
===================

// Module: sa_skew_feeder
// PURPOSE
//  Streaming front end for the ternary systolic array. Accepts one X vector (ROWS lanes) and one
//  W vector (COLS lanes) per beat over valid/ready and applies the triangular skew: lane i is
//  delayed i cycles. Frames K-beat tiles, emits per-row accumulator-clear tags, drains the array
//  with zeros after the last beat, and pulses tile_done when the final product has landed.
// PARAMETERS
//  WIDTH   16   X element width (signed)
//  WW      2    W element width (ternary code; 0 = zero weight)
//  ROWS    128  X lanes = array rows
//  COLS    64   W lanes = array columns
//  K_MAX   256  max beats per tile; beat counter width = $clog2(K_MAX+1)
//  PE_LAT  1    PE multiply-accumulate latency, in cycles
// PORTS
//  clock      in   1              rising-edge clock
//  rst_n      in   1              asynchronous, active-low reset
//  in_valid   in   1              beat valid
//  in_ready   out  1              beat accepted when in_valid & in_ready
//  in_last    in   1              final beat of the current tile
//  x_in       in   ROWS*WIDTH     signed X vector, lane 0 in the LSBs
//  w_in       in   COLS*WW        W vector, lane 0 in the LSBs
//  x_skew     out  ROWS*WIDTH     skewed X to array rows
//  w_skew     out  COLS*WW        skewed W to array columns
//  clr_skew   out  ROWS           per-row "first beat of tile" tag, skewed with x_skew
//  busy       out  1              FSM not in IDLE
//  tile_done  out  1              one-cycle pulse: Y_out of the array is final
//  tile_len   out  $clog2(K_MAX+1)  beats in the last completed tile; valid with tile_done, held after
//  k_ovf      out  1              sticky: a tile hit K_MAX beats without in_last
// BEHAVIOUR
//  Reset: all delay registers, x_skew, w_skew, clr_skew, tile_len, k_ovf, counters = 0;
//   busy = 0; tile_done = 0; FSM = IDLE. Reset is async assert, sync deassert (done externally).
//  Skew: beat accepted at edge t -> x lane i on x_skew at cycles t+1+i; w lane j at t+1+j.
//   Lane 0 has 1 register stage; lane n has n+1 stages.
//   Each cycle without an accepted beat injects zeros (X = 0, W = 0, clr = 0) at the head of each lane.
//  clr_skew[i] = 1 when the tile's first beat is on x lane i.
//  FSM IDLE:
//   in_ready = 1. An accepted beat loads the head, sets clr, sets beat_cnt = 1.
//   Next state: STREAM, or DRAIN if in_last.
//  FSM STREAM:
//   in_ready = 1. Each accepted beat increments beat_cnt; in_valid low inserts a bubble (no count).
//   in_last accepted -> DRAIN.
//   beat_cnt reaching K_MAX on an accepted beat without in_last: the beat is treated as last,
//   k_ovf is set, and the FSM goes to DRAIN.
//  FSM DRAIN:
//   in_ready = 0; zeros injected.
//   drain_cnt is loaded on entry with ROWS+COLS-2+PE_LAT and decrements each cycle.
//   At 0: tile_done = 1 for one cycle, tile_len <= beat_cnt, FSM -> IDLE. Elapsed time is
//   ROWS+COLS-1+PE_LAT cycles from the last-beat edge to tile_done.
//  tile_done cycle: in_ready is already 1 in IDLE the same cycle, so back-to-back tiles are allowed.
//   A beat accepted there starts a new tile; its clr tags trail the old tile's last data by one slot.
//  Single-beat tile (in_last on the IDLE beat): legal; goes straight to DRAIN.
//  Reset mid-tile: all in-flight skew data is discarded, no tile_done, k_ovf cleared.
//  Arithmetic: no arithmetic on data; pure delay. Counters saturate only via the FSM rules above.
// TESTING
//  1 Reset: drive rst_n=0 mid-STREAM -> outputs 0, busy=0, in_ready=1 and tile_done=0
//    immediately (async), not waiting for a clock edge.
//  2 ROWS=4, COLS=3, K=1, x={4,3,2,1}, w={1,2,1}, last -> x_skew lane i = x[i] only at t+1+i;
//    clr_skew walks 0001,0010,0100,1000; tile_done at t+4+3-1+1 = t+7.
//  3 K=5 with in_valid low on beats 2 and 4 -> zero bubbles in every lane at the right skew;
//    tile_len=5; end-to-end Y matches the golden matmul.
//  4 Two tiles back-to-back, second beat presented in the tile_done cycle -> accepted;
//    second clr tags never overlap first-tile data.
//  5 K_MAX=4, 6 beats without in_last -> beat 4 is treated as last, k_ovf=1, in_ready=0
//    during DRAIN, tile_len=4.
//  6 Random X/W at full throughput for 1000 tiles vs the reference model -> zero mismatches.

Source files
------------

// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: frames K-beat tiles of X/W vectors and applies the triangular skew feeding the systolic array.
// Latency: x lane i and w lane j appear i+1 / j+1 cycles after acceptance; tile_done ROWS+COLS-1+PE_LAT cycles after the last beat.
// Backpressure: in_ready is low only while the array drains; cycles without a beat inject zeros into every lane.
module sa_skew_feeder #(
  parameter int WIDTH  = 16,
  parameter int WW     = 2,
  parameter int ROWS   = 128,
  parameter int COLS   = 64,
  parameter int K_MAX  = 256,
  parameter int PE_LAT = 1
) (
  input  logic                         clock,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [ROWS*WIDTH-1:0]        x_in,
  input  logic [COLS*WW-1:0]           w_in,
  output logic [ROWS*WIDTH-1:0]        x_skew,
  output logic [COLS*WW-1:0]           w_skew,
  output logic [ROWS-1:0]              clr_skew,
  output logic                         busy,
  output logic                         tile_done,
  output logic [$clog2(K_MAX+1)-1:0]   tile_len,
  output logic                         k_ovf
);

  localparam int KW        = $clog2(K_MAX + 1);
  // Cycles spent in DRAIN: the last product lands in PE(ROWS-1,COLS-1)
  // ROWS+COLS-2 hops after the skew head, plus the PE latency.
  localparam int DRAIN_CYC = ROWS + COLS - 2 + PE_LAT;
  localparam int DW        = $clog2(DRAIN_CYC + 1);
  // The counter holds "remaining DRAIN cycles minus one" so the done pulse is
  // registered and shows up in the first IDLE cycle, where in_ready is high.
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(K_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [KW-1:0]   tile_len_q, tile_len_d;
  logic            k_ovf_q, k_ovf_d;
  logic            tile_done_q, tile_done_d;

  logic            accept;
  logic            first_beat;
  logic [KW-1:0]   beat_nxt;

  // Tile framing: handshake, beat counting, overflow detection and drain timing.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    tile_len_d  = tile_len_q;
    k_ovf_d     = k_ovf_q;
    tile_done_d = 1'b0;
    in_ready    = 1'b0;
    accept      = 1'b0;
    first_beat  = 1'b0;
    beat_nxt    = beat_cnt_q + KW'(1);
    unique case (state_q)
      S_IDLE, S_STREAM: begin
        in_ready   = 1'b1;
        accept     = in_valid;
        first_beat = in_valid && (state_q == S_IDLE);
        beat_nxt   = first_beat ? KW'(1) : beat_cnt_q + KW'(1);
        if (accept) begin
          beat_cnt_d = beat_nxt;
          // A tile that reaches K_MAX is closed as if in_last had been seen.
          if (in_last || (beat_nxt == K_LAST)) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
            if (!in_last) begin
              k_ovf_d = 1'b1;
            end
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d     = S_IDLE;
          tile_done_d = 1'b1;
          tile_len_d  = beat_cnt_q;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      tile_len_q  <= '0;
      k_ovf_q     <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      tile_len_q  <= tile_len_d;
      k_ovf_q     <= k_ovf_d;
      tile_done_q <= tile_done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign tile_done = tile_done_q;
  assign tile_len  = tile_len_q;
  assign k_ovf     = k_ovf_q;

  // X lanes: lane i is an (i+1)-deep shift register; the clear tag rides alongside.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [WIDTH-1:0] x_pipe_d [0:gi];
    logic [WIDTH-1:0] x_pipe_q [0:gi];
    logic             c_pipe_d [0:gi];
    logic             c_pipe_q [0:gi];

    // Head takes the accepted element (or zero); later stages shift by one.
    always_comb begin
      x_pipe_d[0] = accept ? x_in[gi*WIDTH +: WIDTH] : '0;
      c_pipe_d[0] = first_beat;
      for (int s = 1; s <= gi; s++) begin
        x_pipe_d[s] = x_pipe_q[s-1];
        c_pipe_d[s] = c_pipe_q[s-1];
      end
    end

    // Lane storage; reset flushes any in-flight tile.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= gi; s++) begin
          x_pipe_q[s] <= '0;
          c_pipe_q[s] <= 1'b0;
        end
      end else begin
        for (int s = 0; s <= gi; s++) begin
          x_pipe_q[s] <= x_pipe_d[s];
          c_pipe_q[s] <= c_pipe_d[s];
        end
      end
    end

    assign x_skew[gi*WIDTH +: WIDTH] = x_pipe_q[gi];
    assign clr_skew[gi]              = c_pipe_q[gi];
  end

  // W lanes: lane j is a (j+1)-deep shift register.
  for (genvar gj = 0; gj < COLS; gj++) begin : g_col
    logic [WW-1:0] w_pipe_d [0:gj];
    logic [WW-1:0] w_pipe_q [0:gj];

    // Head takes the accepted weight code (or the zero code); later stages shift.
    always_comb begin
      w_pipe_d[0] = accept ? w_in[gj*WW +: WW] : '0;
      for (int s = 1; s <= gj; s++) begin
        w_pipe_d[s] = w_pipe_q[s-1];
      end
    end

    // Lane storage; reset flushes any in-flight tile.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= gj; s++) begin
          w_pipe_q[s] <= '0;
        end
      end else begin
        for (int s = 0; s <= gj; s++) begin
          w_pipe_q[s] <= w_pipe_d[s];
        end
      end
    end

    assign w_skew[gj*WW +: WW] = w_pipe_q[gj];
  end

endmodule
